// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit adder: result = word1 + sign-extended word2, one nibble per clock.
// busy drops combinationally in the cycle the final nibble is committed.
module loop_over_all_nibbles (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loop_perm_to_count,
  input  logic [2:0]  loop_nibbles_number,
  input  logic        word2_is_negative,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  input  logic [31:0] preinit_result,
  output logic [31:0] result,
  output logic        busy,
  output logic [3:0]  ctrl
);

  logic        carry;
  logic [2:0]  idx;
  logic        done;
  logic [4:0]  bit_pos;
  logic [3:0]  w1n;
  logic [3:0]  w2n;
  logic [4:0]  sum;
  logic        last;
  logic [31:0] next_result;

  always_comb begin
    bit_pos = {idx, 2'b00};
    w1n     = word1[bit_pos +: 4];
    if (idx <= loop_nibbles_number) begin
      w2n = word2[bit_pos +: 4];
    end else begin
      w2n = {4{word2_is_negative}};
    end
    sum  = {1'b0, w1n} + {1'b0, w2n} + {4'b0000, carry};
    // Once word2's own nibbles are consumed, a carry equal to the sign means
    // every higher nibble of the sum is just word1.
    last = (idx >= loop_nibbles_number) &&
           ((sum[4] == word2_is_negative) || (idx == 3'd7));
    // Nibble 0 also loads the untouched upper nibbles from word1.
    next_result = (idx == 3'd0) ? word1 : result;
    next_result[bit_pos +: 4] = sum[3:0];
    busy = rst_n & loop_perm_to_count & ~done & ~last;
    ctrl = {carry, idx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
    end else if (!loop_perm_to_count) begin
      result <= preinit_result;
      carry  <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
    end else if (!done) begin
      result <= next_result;
      carry  <= sum[4];
      if (last) begin
        done <= 1'b1;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Directed bench for loop_over_all_nibbles: vector table plus reset/abort/idle sequences.
module tb_loop_over_all_nibbles;

  logic        clk;
  logic        rst_n;
  logic        perm;
  logic [2:0]  nibbles;
  logic        neg;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [31:0] preinit;
  logic [31:0] result;
  logic        busy;
  logic [3:0]  ctrl;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [3:0]  ctrl_log [0:15];
  logic        busy_log [0:15];
  int unsigned run_cycles;

  typedef struct {
    logic [31:0] w1;
    logic [31:0] w2;
    logic [2:0]  n;
    logic        neg;
    logic [31:0] exp_result;
    int unsigned exp_cycles;
  } vec_t;

  vec_t vecs [0:7];

  loop_over_all_nibbles dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .loop_perm_to_count  (perm),
    .loop_nibbles_number (nibbles),
    .word2_is_negative   (neg),
    .word1               (word1),
    .word2               (word2),
    .preinit_result      (preinit),
    .result              (result),
    .busy                (busy),
    .ctrl                (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at a negedge, leaves permission high, returns at the negedge after the final commit.
  task automatic run_op(input logic [31:0] w1, input logic [31:0] w2,
                        input logic [2:0] n, input logic ng);
    bit fin;
    word1 = w1; word2 = w2; nibbles = n; neg = ng; perm = 1'b1;
    fin = 1'b0;
    run_cycles = 0;
    for (int c = 0; c < 12 && !fin; c++) begin
      #1;
      ctrl_log[c] = ctrl;
      busy_log[c] = busy;
      run_cycles++;
      if (!busy) fin = 1'b1;
      @(negedge clk);
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: busy still high after %0d cycles", run_cycles);
    end
  endtask

  task automatic go_idle();
    perm = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{32'h0000_00FF, 32'h0000_0004, 3'd0, 1'b0, 32'h0000_0103, 3};
    vecs[1] = '{32'h0000_0000, 32'h0000_007B, 3'd2, 1'b0, 32'h0000_007B, 3};
    vecs[2] = '{32'h0000_007B, 32'h0000_0002, 3'd2, 1'b0, 32'h0000_007D, 3};
    vecs[3] = '{32'h0000_007B, 32'h0000_0FFE, 3'd2, 1'b1, 32'h0000_0079, 3};
    vecs[4] = '{32'h0000_0000, 32'h0000_0800, 3'd2, 1'b1, 32'hFFFF_F800, 8};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd7, 1'b0, 32'h0000_0000, 8};
    vecs[6] = '{32'h1234_5678, 32'h0000_0001, 3'd0, 1'b0, 32'h1234_5679, 1};
    vecs[7] = '{32'h0000_0010, 32'hABCD_EF05, 3'd0, 1'b0, 32'h0000_0015, 1};

    rst_n = 1'b0; perm = 1'b0; nibbles = '0; neg = 1'b0;
    word1 = '0; word2 = '0; preinit = 32'hDEAD_BEEF;
    #12;
    check("reset_result", result, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_ctrl", {28'h0, ctrl}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    preinit = 32'h1234_5678;
    @(negedge clk);
    check("idle_preinit", result, 32'h1234_5678);
    check("idle_ctrl", {28'h0, ctrl}, 32'h0);
    perm = 1'b0;
    #1;
    check("idle_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].w1, vecs[i].w2, vecs[i].n, vecs[i].neg);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("vec%0d_cycles", i), run_cycles, vecs[i].exp_cycles);
      if (i == 0) begin
        check("vec0_busy_c0", {31'h0, busy_log[0]}, 32'h1);
        check("vec0_busy_c1", {31'h0, busy_log[1]}, 32'h1);
        check("vec0_busy_c2", {31'h0, busy_log[2]}, 32'h0);
        check("vec0_ctrl_c0", {28'h0, ctrl_log[0]}, 32'h0);
        check("vec0_ctrl_c1", {28'h0, ctrl_log[1]}, 32'h9);
        check("vec0_ctrl_c2", {28'h0, ctrl_log[2]}, 32'hA);
      end
      if (i == 5) begin
        // permission still high after completion: result holds, busy stays low
        @(negedge clk);
        #1;
        check("done_hold_result", result, 32'h0);
        check("done_hold_busy", {31'h0, busy}, 32'h0);
      end
      go_idle();
    end

    // abort by dropping permission mid-operation
    preinit = 32'hCAFE_F00D;
    @(negedge clk);
    word1 = 32'h0; word2 = 32'h800; nibbles = 3'd2; neg = 1'b1; perm = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    perm = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("abort_result", result, 32'hCAFE_F00D);
    check("abort_ctrl", {28'h0, ctrl}, 32'h0);

    // async reset mid-operation
    word1 = 32'hFFFF_FFFF; word2 = 32'h1; nibbles = 3'd7; neg = 1'b0; perm = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_ctrl", {28'h0, ctrl}, 32'h0);
    @(negedge clk);
    perm = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // fresh operation after reset recovery
    run_op(32'h0000_00FF, 32'h0000_0004, 3'd0, 1'b0);
    check("post_rst_result", result, 32'h0000_0103);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
